// File: rtl/adder32_pkg.sv
// Shared sizing constants and the per-stage record for the pipelined 32-bit adder.
// A stage record carries everything a beat needs to finish its addition further down the pipe.
package adder32_pkg;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int SLICE  = WIDTH / STAGES;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic             carry;      // carry into the next slice; carry out of the MSB in the last stage
    logic             msb_carry;  // carry into bit WIDTH-1, for signed overflow
  } stage_t;

endpackage

// File: rtl/add_slice.sv
// Combinational W-bit ripple chain of full-adder cells; also exposes the carry into its top bit.
// Zero latency, no handshake.
module add_slice
  import adder32_pkg::*;
#(
  parameter int W = SLICE
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // Each bit owns its carry nets so the ripple is a chain of distinct signals.
  for (genvar i = 0; i < W; i++) begin : g_bit
    logic cin_bit;
    logic co_bit;

    if (i == 0) begin : g_lsb
      assign cin_bit = ci;
    end else begin : g_up
      assign cin_bit = g_bit[i-1].co_bit;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (cin_bit),
      .s  (s[i]),
      .co (co_bit)
    );
  end

  assign co    = g_bit[W-1].co_bit;
  assign c_msb = g_bit[W-1].cin_bit;

endmodule

// File: rtl/full_adder.sv
// 1-bit full-adder cell: s = a ^ b ^ ci, co = majority(a, b, ci).
// Purely combinational, no state, no handshake.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_adder32.sv
// Pipelined 32-bit ripple adder, one SLICE-bit chain per stage; result is 4 registers after acceptance.
// Valid/ready on both sides; in_ready follows out_ready through the advance chain, empty stages refill under a stall.
module pipe_adder32
  import adder32_pkg::*;
#(
  parameter int WIDTH  = adder32_pkg::WIDTH,
  parameter int STAGES = adder32_pkg::STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE_W = WIDTH / STAGES;

  if ((WIDTH != adder32_pkg::WIDTH) || (STAGES != adder32_pkg::STAGES) ||
      (WIDTH % STAGES != 0)) begin : g_cfg_err
    $error("pipe_adder32: WIDTH/STAGES must match adder32_pkg and divide evenly");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;

  // Walking back from the output, a stage may move if any later stage is empty or the consumer takes.
  always_comb begin
    logic room;
    room = out_ready;
    adv  = '0;
    load = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = vld[i] & room;
      room   = room | ~vld[i];
    end
    in_ready = ~rst & room;
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < STAGES; i++) begin
      load[i] = adv[i-1];
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    stage_t              stage_q;
    stage_t              stage_d;
    stage_t              src;
    logic [SLICE_W-1:0]  slice_s;
    logic                slice_co;
    logic                slice_cmsb;

    if (i == 0) begin : g_in
      always_comb begin
        src       = '0;
        src.vld   = in_valid;
        src.a_rem = a;
        src.b_rem = b;
        src.carry = cin;
      end
    end else begin : g_mid
      assign src = g_stage[i-1].stage_q;
    end

    add_slice #(
      .W (SLICE_W)
    ) u_slice (
      .a     (src.a_rem[i*SLICE_W +: SLICE_W]),
      .b     (src.b_rem[i*SLICE_W +: SLICE_W]),
      .ci    (src.carry),
      .s     (slice_s),
      .co    (slice_co),
      .c_msb (slice_cmsb)
    );

    always_comb begin
      stage_d = stage_q;
      if (load[i]) begin
        stage_d                             = src;
        stage_d.vld                         = 1'b1;
        stage_d.psum[i*SLICE_W +: SLICE_W]  = slice_s;
        stage_d.carry                       = slice_co;
        if (i == STAGES - 1) begin
          stage_d.msb_carry = slice_cmsb;
        end
      end else if (adv[i]) begin
        stage_d.vld = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        stage_q <= '0;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign vld[i] = stage_q.vld;
  end

  assign out_valid = g_stage[STAGES-1].stage_q.vld;
  assign sum       = g_stage[STAGES-1].stage_q.psum;
  assign cout      = g_stage[STAGES-1].stage_q.carry;
  assign ovf       = g_stage[STAGES-1].stage_q.msb_carry ^ g_stage[STAGES-1].stage_q.carry;

endmodule
